// File: rtl/mem_lsu_split.sv
// rtl/mem_lsu_split.sv - load/store unit that splits lane-crossing accesses into two big-endian bus beats
module mem_lsu_split #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_fn4,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_mask,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err
);
    localparam int LANES = XLEN / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam logic [LANES-1:0] MASK_ONE = {{(LANES-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  XLEN_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              unused_fn4;
    assign unused_fn4 = req_fn4[2];

    int                n_bytes, ofs, k;
    logic              split, beat1, in_req;
    logic [LANES-1:0]  lane_mask;
    logic [XLEN-1:0]   lane_wdata, gathered, extended, sh, sh_sign;
    logic [ADDR_W-1:0] base_addr;

    always_comb begin
        case (size_q)
            2'd0:    n_bytes = 1;
            2'd1:    n_bytes = 2;
            2'd2:    n_bytes = 4;
            default: n_bytes = 8;
        endcase
        if (n_bytes > LANES) n_bytes = LANES;
        ofs       = int'(addr_q[OFS_W-1:0]);
        split     = (ofs + n_bytes) > LANES;
        beat1     = (state_q == REQ1) || (state_q == WAIT1);
        in_req    = (state_q == REQ0) || (state_q == REQ1);
        base_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    end

    // k is the byte index within the access (0 = most significant) that lane l carries in this beat
    always_comb begin
        k          = 0;
        sh         = '0;
        lane_mask  = '0;
        lane_wdata = '0;
        gathered   = acc_q;
        for (int l = 0; l < LANES; l++) begin
            k = l + (beat1 ? LANES : 0) - ofs;
            if (k >= 0 && k < n_bytes) begin
                lane_mask  = lane_mask | (MASK_ONE << (LANES - 1 - l));
                sh         = wdata_q >> (8 * (n_bytes - 1 - k));
                lane_wdata = lane_wdata | ({sh[7:0], {(XLEN-8){1'b0}}} >> (8 * l));
                sh         = bus_rdata << (8 * l);
                gathered   = gathered | ({{(XLEN-8){1'b0}}, sh[XLEN-1 -: 8]} << (8 * (n_bytes - 1 - k)));
            end
        end
        sh_sign  = gathered >> (8 * n_bytes - 1);
        extended = gathered;
        if (sgn_q && n_bytes < LANES && sh_sign[0])
            extended = gathered | ~((XLEN_ONE << (8 * n_bytes)) - XLEN_ONE);
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_fn4[1:0];
                    sgn_d   = req_fn4[3];
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    acc_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = REQ0;
                end
            end
            REQ0: if (bus_ready) state_d = WAIT0;
            REQ1: if (bus_ready) state_d = WAIT1;
            WAIT0, WAIT1: begin
                if (bus_rvalid) begin
                    err_d = err_q | bus_err;
                    if (!we_q) acc_d = gathered;
                    // an error on beat0 abandons the second beat
                    if (state_q == WAIT0 && split && !bus_err) begin
                        state_d = REQ1;
                    end else begin
                        state_d = DONE;
                        rdata_d = (we_q || err_q || bus_err) ? '0 : extended;
                    end
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus_valid = in_req;
    assign bus_we    = in_req && we_q;
    assign bus_addr  = in_req ? (beat1 ? base_addr + ADDR_W'(LANES) : base_addr) : '0;
    assign bus_mask  = in_req ? lane_mask : '0;
    assign bus_wdata = (in_req && we_q) ? lane_wdata : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_mem_lsu_split.sv
// tb/tb_mem_lsu_split.sv - scoreboard bench for mem_lsu_split at XLEN 32 and 64
`timescale 1ns/1ps
module tb_mem_lsu_split;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_fn4;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    logic        w_req_valid, w_req_ready, w_req_we;
    logic [3:0]  w_req_fn4;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_rsp_valid, w_rsp_err;
    logic [63:0] w_rsp_rdata;
    logic        w_bus_valid, w_bus_ready, w_bus_we;
    logic [31:0] w_bus_addr;
    logic [63:0] w_bus_wdata;
    logic [7:0]  w_bus_mask;
    logic        w_bus_rvalid, w_bus_err;
    logic [63:0] w_bus_rdata;

    mem_lsu_split #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_fn4(req_fn4),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_mask(bus_mask), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    mem_lsu_split #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we), .req_fn4(w_req_fn4),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err),
        .bus_valid(w_bus_valid), .bus_ready(w_bus_ready), .bus_we(w_bus_we), .bus_addr(w_bus_addr),
        .bus_wdata(w_bus_wdata), .bus_mask(w_bus_mask), .bus_rvalid(w_bus_rvalid),
        .bus_rdata(w_bus_rdata), .bus_err(w_bus_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q32[$];
    logic [63:0] q64[$];
    exp_t        e32;
    logic [63:0] e64;

    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            checks++;
            if (q32.size() == 0) begin
                failures++;
                $display("FAIL rsp32_unexpected got rdata=%h err=%b required no response", rsp_rdata, rsp_err);
            end else begin
                e32 = q32.pop_front();
                if (rsp_rdata !== e32.rdata || rsp_err !== e32.err) begin
                    failures++;
                    $display("FAIL rsp32 got rdata=%h err=%b required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e32.rdata, e32.err);
                end
            end
        end
        if (!rst && w_rsp_valid === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                failures++;
                $display("FAIL rsp64_unexpected got rdata=%h required no response", w_rsp_rdata);
            end else begin
                e64 = q64.pop_front();
                if (w_rsp_rdata !== e64 || w_rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rsp64 got rdata=%h err=%b required rdata=%h err=0", w_rsp_rdata, w_rsp_err, e64);
                end
            end
        end
    end

    task automatic push32(input logic [31:0] d, input logic e);
        exp_t t;
        t.rdata = d;
        t.err   = e;
        q32.push_back(t);
    endtask

    task automatic do_req(input logic we, input logic [3:0] fn4, input logic [31:0] addr, input logic [31:0] wdata);
        int i;
        req_valid = 1'b1;
        req_we    = we;
        req_fn4   = fn4;
        req_addr  = addr;
        req_wdata = wdata;
        for (i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_accept addr=%h got req_ready=%b required 1", addr, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] em, input logic [31:0] ew,
                        input logic ewe, input logic [31:0] rd, input logic er);
        int i;
        for (i = 0; i < 20 && bus_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got bus_valid=%b required 1", tag, bus_valid);
        end
        checks++;
        if (bus_addr !== ea || bus_mask !== em) begin
            failures++;
            $display("FAIL %s_addr_mask got addr=%h mask=%b required addr=%h mask=%b", tag, bus_addr, bus_mask, ea, em);
        end
        checks++;
        if (bus_wdata !== ew || bus_we !== ewe) begin
            failures++;
            $display("FAIL %s_wdata got wdata=%h we=%b required wdata=%h we=%b", tag, bus_wdata, bus_we, ew, ewe);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        bus_err    = er;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int i;
        for (i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
        if (q32.size() != 0 || q64.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_rsp_timeout got pending=%0d required 0", tag, q32.size() + q64.size());
            q32.delete();
            q64.delete();
        end
    endtask

    task automatic run_auto(output int lat);
        int k;
        logic pending;
        pending = 1'b0;
        for (k = 0; k < 30; k++) begin
            if (rsp_valid === 1'b1) break;
            bus_rvalid = pending;
            pending    = bus_valid && bus_ready;
            @(negedge clk);
        end
        bus_rvalid = 1'b0;
        lat = k + 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_fn4 = 0; req_addr = 0; req_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
        w_req_valid = 0; w_req_we = 0; w_req_fn4 = 0; w_req_addr = 0; w_req_wdata = 0;
        w_bus_ready = 0; w_bus_rvalid = 0; w_bus_rdata = 0; w_bus_err = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_valid, rsp_valid, rsp_err, bus_we, req_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 00001", {bus_valid, rsp_valid, rsp_err, bus_we, req_ready});
        end
        checks++;
        if ({rsp_rdata, bus_addr, bus_wdata, bus_mask} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h mask=%b required all zero",
                     rsp_rdata, bus_addr, bus_wdata, bus_mask);
        end
        checks++;
        if ({w_bus_valid, w_rsp_valid, w_req_ready, w_bus_mask} !== 11'b00100000000) begin
            failures++;
            $display("FAIL reset_64 got valid=%b rsp=%b ready=%b mask=%b required 0 0 1 0",
                     w_bus_valid, w_rsp_valid, w_req_ready, w_bus_mask);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_byte;
        push32(32'h0, 1'b0);
        do_req(1'b1, 4'b0000, 32'h1001, 32'h000000AB);
        beat("sb", 32'h1000, 4'b0100, 32'h00AB0000, 1'b1, 32'hFFFFFFFF, 1'b0);
        wait_rsp("sb");
    endtask

    task automatic test_loads;
        logic [3:0]  fn[7]   = '{4'b0001, 4'b1001, 4'b1000, 4'b0000, 4'b0011, 4'b1010, 4'b1011};
        logic [31:0] ad[7]   = '{32'h3002, 32'h3002, 32'h3000, 32'h3003, 32'h3000, 32'h3004, 32'h3008};
        logic [3:0]  mk[7]   = '{4'b0011, 4'b0011, 4'b1000, 4'b0001, 4'b1111, 4'b1111, 4'b1111};
        logic [31:0] rd[7]   = '{32'h12348001, 32'h12348001, 32'h9A345678, 32'h9A3456F0,
                                 32'h11223344, 32'h80000001, 32'hF0000000};
        logic [31:0] ex[7]   = '{32'h00008001, 32'hFFFF8001, 32'hFFFFFF9A, 32'h000000F0,
                                 32'h11223344, 32'h80000001, 32'hF0000000};
        for (int i = 0; i < 7; i++) begin
            push32(ex[i], 1'b0);
            do_req(1'b0, fn[i], ad[i], 32'hCAFEF00D);
            beat("ld", ad[i] & 32'hFFFFFFFC, mk[i], 32'h0, 1'b0, rd[i], 1'b0);
            wait_rsp("ld");
        end
    endtask

    task automatic test_split_half;
        push32(32'hFFFF8012, 1'b0);
        do_req(1'b0, 4'b1001, 32'h1003, 32'h0);
        beat("sh0", 32'h1000, 4'b0001, 32'h0, 1'b0, 32'h00000080, 1'b0);
        beat("sh1", 32'h1004, 4'b1000, 32'h0, 1'b0, 32'h12000000, 1'b0);
        wait_rsp("sh");
    endtask

    task automatic test_word_store_split;
        push32(32'h0, 1'b0);
        do_req(1'b1, 4'b0010, 32'h2002, 32'hDEADBEEF);
        beat("sw0", 32'h2000, 4'b0011, 32'h0000DEAD, 1'b1, 32'h12345678, 1'b0);
        beat("sw1", 32'h2004, 4'b1100, 32'hBEEF0000, 1'b1, 32'h9ABCDEF0, 1'b0);
        wait_rsp("sw");
    endtask

    task automatic test_wrap;
        push32(32'hAABBCCDD, 1'b0);
        do_req(1'b0, 4'b0010, 32'hFFFFFFFE, 32'h0);
        beat("wr0", 32'hFFFFFFFC, 4'b0011, 32'h0, 1'b0, 32'h0000AABB, 1'b0);
        beat("wr1", 32'h00000000, 4'b1100, 32'h0, 1'b0, 32'hCCDD0000, 1'b0);
        wait_rsp("wr");
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_rdata !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL rdata_hold got %h required aabbccdd", rsp_rdata);
        end
    endtask

    task automatic test_err;
        logic seen;
        push32(32'h0, 1'b1);
        do_req(1'b0, 4'b0010, 32'h6003, 32'h0);
        beat("er0", 32'h6000, 4'b0001, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL err_no_beat1 got bus_valid=1 required 0");
        end
        wait_rsp("er");
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL err_hold got rsp_err=%b required 1", rsp_err);
        end
        push32(32'h0, 1'b0);
        do_req(1'b1, 4'b0000, 32'h1002, 32'h0000005A);
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_accept got rsp_err=%b required 0", rsp_err);
        end
        beat("er1", 32'h1000, 4'b0010, 32'h00005A00, 1'b1, 32'h0, 1'b0);
        wait_rsp("er1");
    endtask

    task automatic test_back_to_back;
        int lat;
        bus_ready = 1'b1;
        bus_rdata = 32'h55667788;
        push32(32'h55667788, 1'b0);
        do_req(1'b0, 4'b0010, 32'h4000, 32'h0);
        run_auto(lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL latency_single got %0d required 3", lat);
        end
        push32(32'h00008855, 1'b0);
        do_req(1'b0, 4'b0001, 32'h4003, 32'h0);
        run_auto(lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency_split got %0d required 5", lat);
        end
        bus_ready = 1'b0;
        wait_rsp("b2b");
    endtask

    task automatic test_reset_mid;
        logic seen;
        do_req(1'b0, 4'b0010, 32'h5001, 32'h0);
        beat("rm0", 32'h5000, 4'b0111, 32'h0, 1'b0, 32'h11223344, 1'b0);
        for (int i = 0; i < 20 && bus_valid !== 1'b1; i++) @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_valid, rsp_valid, req_ready, rsp_err} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_wait1 got valid/rsp/ready/err=%b required 0010",
                     {bus_valid, rsp_valid, req_ready, rsp_err});
        end
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADDEAD;
        @(negedge clk);
        bus_rvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL stray_rvalid got activity after reset required idle");
        end
        do_req(1'b1, 4'b0000, 32'h7000, 32'h00000011);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_req0 got bus_valid=%b required 0", bus_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        push32(32'h0, 1'b0);
        do_req(1'b1, 4'b0001, 32'h7002, 32'h0000C3A5);
        beat("rm1", 32'h7000, 4'b0011, 32'h0000C3A5, 1'b1, 32'h0, 1'b0);
        wait_rsp("rm1");
    endtask

    task automatic beat64(input string tag, input logic [31:0] ea, input logic [7:0] em, input logic [63:0] rd);
        int i;
        for (i = 0; i < 20 && w_bus_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (w_bus_valid !== 1'b1 || w_bus_addr !== ea || w_bus_mask !== em || w_bus_we !== 1'b0) begin
            failures++;
            $display("FAIL %s got valid=%b addr=%h mask=%b we=%b required 1 %h %b 0",
                     tag, w_bus_valid, w_bus_addr, w_bus_mask, w_bus_we, ea, em);
        end
        w_bus_ready = 1'b1;
        @(negedge clk);
        w_bus_ready  = 1'b0;
        w_bus_rvalid = 1'b1;
        w_bus_rdata  = rd;
        @(negedge clk);
        w_bus_rvalid = 1'b0;
    endtask

    task automatic test_dword64;
        int i;
        q64.push_back(64'hA1A2A3B1B2B3B4B5);
        w_req_valid = 1'b1;
        w_req_we    = 1'b0;
        w_req_fn4   = 4'b0011;
        w_req_addr  = 32'h00001005;
        for (i = 0; i < 20 && w_req_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        w_req_valid = 1'b0;
        beat64("dw0", 32'h00001000, 8'b00000111, 64'hFFFFFFFFFFA1A2A3);
        beat64("dw1", 32'h00001008, 8'b11111000, 64'hB1B2B3B4B5FFFFFF);
        wait_rsp("dw");
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_split_half();
        test_word_store_split();
        test_wrap();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_dword64();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
